mem_arb_ctrl: RTL and testbench

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_if.sv | 45 ++++
 rtl/mem_lat_cnt.sv | 27 ++
 rtl/mem_arb_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_arb_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
// Holds the FSM state encoding, the data width and the latency-counter sizing.
package mem_arb_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_e;

    // Bits needed to hold LAT-1; never narrower than one bit.
    function automatic int cnt_w(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Pipeline/RAM side of the arbiter: fetch and MEM-stage requests, RAM port,
// returned words and the pipeline stall/flush controls.
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_q;

    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic [DATA_W-1:0] data_rdata;
    logic              data_valid;

    logic              if_stall_n;
    logic              pipe_stall_n;
    logic              idex_flush;
    logic              wb_flush;

    // Pipeline and RAM model side.
    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_q,
        input  ram_en, ram_we, ram_a, ram_d,
        input  instr_out, instr_valid, data_rdata, data_valid,
        input  if_stall_n, pipe_stall_n, idex_flush, wb_flush
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_q,
        output ram_en, ram_we, ram_a, ram_d,
        output instr_out, instr_valid, data_rdata, data_valid,
        output if_stall_n, pipe_stall_n, idex_flush, wb_flush
    );

endinterface

// File: rtl/mem_lat_cnt.sv
// Memory latency down-counter: load on issue, count down while busy,
// flag zero on the completion cycle.
module mem_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arb_ctrl.sv
// Single-port memory arbiter between instruction fetch and MEM-stage data,
// data first; produces pipeline stall/flush controls around each access.
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);

    localparam int            CW       = cnt_w(LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LAT - 1);

    arb_state_e state;
    logic       is_load;
    logic       data_req;
    logic       issue;
    logic       cnt_dec;
    logic       cnt_zero;

    logic              ram_en, ram_we;
    logic [DATA_W-1:0] ram_a, ram_d;
    logic              instr_valid, data_valid;
    logic [DATA_W-1:0] instr_out, data_rdata;
    logic              pipe_stall;

    assign data_req = bus.mem_rd | bus.mem_wr;
    assign issue    = (state == IDLE) & (data_req | bus.if_req);
    assign cnt_dec  = (state != IDLE) & ~cnt_zero;

    mem_lat_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (issue),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            is_load <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req) begin
                        state   <= DATA;
                        is_load <= bus.mem_rd;
                    end else if (bus.if_req) begin
                        state <= FETCH;
                    end
                end
                DATA, FETCH: if (cnt_zero) state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state; everything is held low while in reset.
    always_comb begin
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_a       = '0;
        ram_d       = '0;
        instr_valid = 1'b0;
        instr_out   = '0;
        data_valid  = 1'b0;
        data_rdata  = '0;
        pipe_stall  = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (data_req) begin
                        ram_en     = 1'b1;
                        ram_we     = bus.mem_wr;
                        ram_a      = bus.mem_addr;
                        ram_d      = bus.mem_wdata;
                        pipe_stall = 1'b1;
                    end else if (bus.if_req) begin
                        ram_en = 1'b1;
                        ram_a  = bus.if_addr;
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        if (is_load) begin
                            data_valid = 1'b1;
                            data_rdata = bus.ram_q;
                        end
                    end else begin
                        pipe_stall = 1'b1;
                    end
                end
                FETCH: begin
                    // A waiting MEM-stage access freezes the back end until it gets the port.
                    pipe_stall = data_req;
                    if (cnt_zero) begin
                        instr_valid = 1'b1;
                        instr_out   = bus.ram_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_en       = ram_en;
    assign bus.ram_we       = ram_we;
    assign bus.ram_a        = ram_a;
    assign bus.ram_d        = ram_d;
    assign bus.instr_valid  = instr_valid;
    assign bus.instr_out    = instr_out;
    assign bus.data_valid   = data_valid;
    assign bus.data_rdata   = data_rdata;
    assign bus.if_stall_n   = instr_valid;
    assign bus.pipe_stall_n = rst_n & ~pipe_stall;
    assign bus.wb_flush     = rst_n & pipe_stall;
    assign bus.idex_flush   = rst_n & ~pipe_stall & ~instr_valid;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl (LAT=4): reset, table of per-cycle vectors,
// and a hand-written reset-mid-access sequence.
module tb_mem_arb_ctrl;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mem_arb_if bus();

    mem_arb_ctrl #(.LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        rd, wr;
        logic [15:0] ma, wd, rq;
        logic        en, we;
        logic [15:0] a;
        logic        cd;
        logic [15:0] d;
        logic        iv;
        logic [15:0] io;
        logic        dv;
        logic [15:0] dr;
        logic        ifs, ps, idf, wbf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic ir, input logic [15:0] ia, input logic rd, input logic wr,
        input logic [15:0] ma, input logic [15:0] wd, input logic [15:0] rq,
        input logic en, input logic we, input logic [15:0] a, input logic cd, input logic [15:0] d,
        input logic iv, input logic [15:0] io, input logic dv, input logic [15:0] dr,
        input logic ifs, input logic ps, input logic idf, input logic wbf);
        vec_t t;
        t = '{ir, ia, rd, wr, ma, wd, rq, en, we, a, cd, d, iv, io, dv, dr, ifs, ps, idf, wbf};
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic rd, input logic wr,
                         input logic [15:0] ma, input logic [15:0] wd, input logic [15:0] rq);
        bus.if_req    = ir;
        bus.if_addr   = ia;
        bus.mem_rd    = rd;
        bus.mem_wr    = wr;
        bus.mem_addr  = ma;
        bus.mem_wdata = wd;
        bus.ram_q     = rq;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_en"},   16'(bus.ram_en),       16'd0);
        chk({nm, "_we"},   16'(bus.ram_we),       16'd0);
        chk({nm, "_a"},    bus.ram_a,             16'd0);
        chk({nm, "_d"},    bus.ram_d,             16'd0);
        chk({nm, "_iv"},   16'(bus.instr_valid),  16'd0);
        chk({nm, "_io"},   bus.instr_out,         16'd0);
        chk({nm, "_dv"},   16'(bus.data_valid),   16'd0);
        chk({nm, "_dr"},   bus.data_rdata,        16'd0);
        chk({nm, "_ifs"},  16'(bus.if_stall_n),   16'd0);
        chk({nm, "_ps"},   16'(bus.pipe_stall_n), 16'd0);
        chk({nm, "_idf"},  16'(bus.idex_flush),   16'd0);
        chk({nm, "_wbf"},  16'(bus.wb_flush),     16'd0);
    endtask

    task automatic chk_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("r%0d", i);
        chk({p, "_en"}, 16'(bus.ram_en), 16'(v.en));
        if (v.en) begin
            chk({p, "_we"}, 16'(bus.ram_we), 16'(v.we));
            chk({p, "_a"},  bus.ram_a,       v.a);
        end
        if (v.cd) chk({p, "_d"}, bus.ram_d, v.d);
        chk({p, "_iv"},  16'(bus.instr_valid),  16'(v.iv));
        chk({p, "_io"},  bus.instr_out,         v.io);
        chk({p, "_dv"},  16'(bus.data_valid),   16'(v.dv));
        chk({p, "_dr"},  bus.data_rdata,        v.dr);
        chk({p, "_ifs"}, 16'(bus.if_stall_n),   16'(v.ifs));
        chk({p, "_ps"},  16'(bus.pipe_stall_n), 16'(v.ps));
        chk({p, "_idf"}, 16'(bus.idex_flush),   16'(v.idf));
        chk({p, "_wbf"}, 16'(bus.wb_flush),     16'(v.wbf));
    endtask

    task automatic add_idle();
        add(0,16'h0000,0,0,16'h0000,16'h0000,16'hDEAD, 0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000, 0,1,1,0);
    endtask

    initial begin
        // Fetch 0x0010 at t0, word back at t4.
        add_idle();
        add(1,16'h0010,0,0,16'h0000,16'h0000,16'hDEAD, 1,0,16'h0010,0,16'h0000, 0,16'h0000,0,16'h0000, 0,1,1,0);
        for (int k = 0; k < 3; k++)
            add(1,16'h0010,0,0,16'h0000,16'h0000,16'hDEAD, 0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000, 0,1,1,0);
        add(1,16'h0010,0,0,16'h0000,16'h0000,16'h1234, 0,0,16'h0000,0,16'h0000, 1,16'h1234,0,16'h0000, 1,1,0,0);
        add_idle();
        // Load 0x0040, data back at t4.
        add(0,16'h0000,1,0,16'h0040,16'h0000,16'hDEAD, 1,0,16'h0040,0,16'h0000, 0,16'h0000,0,16'h0000, 0,0,0,1);
        for (int k = 0; k < 3; k++)
            add(0,16'h0000,1,0,16'h0040,16'h0000,16'hDEAD, 0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000, 0,0,0,1);
        add(0,16'h0000,1,0,16'h0040,16'h0000,16'hBEEF, 0,0,16'h0000,0,16'h0000, 0,16'h0000,1,16'hBEEF, 0,1,1,0);
        add_idle();
        // Store and fetch together: store wins, fetch issues at t5.
        add(1,16'h0100,0,1,16'h0200,16'hCAFE,16'hDEAD, 1,1,16'h0200,1,16'hCAFE, 0,16'h0000,0,16'h0000, 0,0,0,1);
        for (int k = 0; k < 3; k++)
            add(1,16'h0100,0,1,16'h0200,16'hCAFE,16'hDEAD, 0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000, 0,0,0,1);
        add(1,16'h0100,0,1,16'h0200,16'hCAFE,16'hFACE, 0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000, 0,1,1,0);
        add(1,16'h0100,0,0,16'h0000,16'h0000,16'hDEAD, 1,0,16'h0100,0,16'h0000, 0,16'h0000,0,16'h0000, 0,1,1,0);
        for (int k = 0; k < 3; k++)
            add(1,16'h0100,0,0,16'h0000,16'h0000,16'hDEAD, 0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000, 0,1,1,0);
        add(1,16'h0100,0,0,16'h0000,16'h0000,16'h5678, 0,0,16'h0000,0,16'h0000, 1,16'h5678,0,16'h0000, 1,1,0,0);
        add_idle();
        // Load arrives during a fetch: back end frozen t1..t4, load issues at t5.
        add(1,16'h0300,0,0,16'h0000,16'h0000,16'hDEAD, 1,0,16'h0300,0,16'h0000, 0,16'h0000,0,16'h0000, 0,1,1,0);
        for (int k = 0; k < 3; k++)
            add(1,16'h0300,1,0,16'h0400,16'h0000,16'hDEAD, 0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000, 0,0,0,1);
        add(1,16'h0300,1,0,16'h0400,16'h0000,16'h9ABC, 0,0,16'h0000,0,16'h0000, 1,16'h9ABC,0,16'h0000, 1,0,0,1);
        add(1,16'h0300,1,0,16'h0400,16'h0000,16'hDEAD, 1,0,16'h0400,0,16'h0000, 0,16'h0000,0,16'h0000, 0,0,0,1);
        for (int k = 0; k < 3; k++)
            add(1,16'h0300,1,0,16'h0400,16'h0000,16'hDEAD, 0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000, 0,0,0,1);
        add(1,16'h0300,1,0,16'h0400,16'h0000,16'h1111, 0,0,16'h0000,0,16'h0000, 0,16'h0000,1,16'h1111, 0,1,1,0);
        add_idle();

        // Reset with every input high.
        rst_n = 1'b0;
        drive(1,16'hFFFF,1,1,16'hFFFF,16'hFFFF,16'hFFFF);
        @(negedge clk);
        chk_all_zero("rst0");
        @(negedge clk);
        chk_all_zero("rst1");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0,16'h0000,0,0,16'h0000,16'h0000,16'h0000);
        @(negedge clk);
        chk("rel_state", 16'(dut.state), 16'(IDLE));
        chk("rel_en", 16'(bus.ram_en), 16'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i].ir, tbl[i].ia, tbl[i].rd, tbl[i].wr, tbl[i].ma, tbl[i].wd, tbl[i].rq);
            @(negedge clk);
            chk_vec(i, tbl[i]);
        end

        // Reset in the middle of a load; a fetch right after release runs normally.
        @(posedge clk); #1;
        drive(0,16'h0000,1,0,16'h0040,16'h0000,16'hDEAD);
        @(negedge clk);
        chk("mr_t0_en", 16'(bus.ram_en), 16'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_t1_ps", 16'(bus.pipe_stall_n), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("mr_t2");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1,16'h0020,0,0,16'h0000,16'h0000,16'hDEAD);
        @(negedge clk);
        chk("mr_t3_en", 16'(bus.ram_en), 16'd1);
        chk("mr_t3_a", bus.ram_a, 16'h0020);
        chk("mr_t3_ifs", 16'(bus.if_stall_n), 16'd0);
        for (int k = 4; k < 7; k++) begin
            @(posedge clk); #1;
            drive(0,16'h0000,0,0,16'h0000,16'h0000,16'hBEEF);
            @(negedge clk);
            chk($sformatf("mr_t%0d_dv", k), 16'(bus.data_valid), 16'd0);
            chk($sformatf("mr_t%0d_dr", k), bus.data_rdata, 16'd0);
            chk($sformatf("mr_t%0d_iv", k), 16'(bus.instr_valid), 16'd0);
        end
        @(posedge clk); #1;
        bus.ram_q = 16'h7777;
        @(negedge clk);
        chk("mr_t7_iv", 16'(bus.instr_valid), 16'd1);
        chk("mr_t7_io", bus.instr_out, 16'h7777);
        chk("mr_t7_dv", 16'(bus.data_valid), 16'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_t8_iv", 16'(bus.instr_valid), 16'd0);
        chk("mr_t8_en", 16'(bus.ram_en), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
